aer_event_receiver: RTL and testbench

- Downstream neighbour of the input interface; receives its 4-phase AER spike stream (AERIN_REQ/AERIN_ADDR/AERIN_ACK) into the SNN core clock domain.
- Synchronises REQ, captures the 10-bit pixel/neuron address and generates ACK.
- Buffers events in a small FIFO and presents them to the core over a valid/ready interface.
- Applies back-pressure to the sender by withholding ACK while the FIFO is full.

---
 rtl/aer_event_receiver.sv | 105 ++++++++++
 tb/tb_aer_event_receiver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_event_receiver.sv
// rtl/aer_event_receiver.sv - 4-phase AER receiver: REQ synchroniser, ACK handshake FSM, event FIFO
module aer_event_receiver #(
  parameter int AER_ADDR_BITS = 10,
  parameter int FIFO_DEPTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_BITS      = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [AER_ADDR_BITS-1:0]       AERIN_ADDR,
  input  logic                           AERIN_REQ,
  output logic                           AERIN_ACK,
  output logic [AER_ADDR_BITS-1:0]       EVENT_ADDR,
  output logic                           EVENT_VALID,
  input  logic                           EVENT_READY,
  input  logic                           FLUSH,
  output logic [$clog2(FIFO_DEPTH):0]    FIFO_COUNT,
  output logic [CNT_BITS-1:0]            EVENT_CNT
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam logic [PTR_BITS:0] PTR_ONE = 1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE, ACK_HI} state_t;

  state_t                    state;
  logic [SYNC_STAGES-1:0]    req_sync;
  logic                      req_s;
  logic [AER_ADDR_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PTR_BITS:0]         wr_ptr;
  logic [PTR_BITS:0]         rd_ptr;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;

  assign req_s = req_sync[SYNC_STAGES-1];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                 (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
  // Full is checked while IDLE, so a handshake simply waits until a pop frees a slot.
  assign push  = (state == IDLE) && req_s && !full;
  assign pop   = !empty && EVENT_READY;

  assign EVENT_ADDR  = mem[rd_ptr[PTR_BITS-1:0]];
  assign EVENT_VALID = !empty;
  assign FIFO_COUNT  = wr_ptr - rd_ptr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], AERIN_REQ};
    end
  end

  // FLUSH deliberately leaves the handshake alone so the sender can always finish its cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      AERIN_ACK <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            AERIN_ACK <= 1'b1;
            state     <= ACK_HI;
          end
        end
        ACK_HI: begin
          if (!req_s) begin
            AERIN_ACK <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          AERIN_ACK <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      EVENT_CNT <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (FLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      EVENT_CNT <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PTR_BITS-1:0]] <= AERIN_ADDR;
        wr_ptr <= wr_ptr + PTR_ONE;
        if (EVENT_CNT != '1) EVENT_CNT <= EVENT_CNT + CNT_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_aer_event_receiver.sv
// tb/tb_aer_event_receiver.sv - randomized and directed bench with a queue-based event model
module tb_aer_event_receiver;

  localparam int AB = 10;
  localparam int DEPTH = 8;
  localparam int SYNC = 2;
  localparam int CB = 16;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic          CLK;
  logic          RST;
  logic [AB-1:0] AERIN_ADDR;
  logic          AERIN_REQ;
  logic          AERIN_ACK;
  logic [AB-1:0] EVENT_ADDR;
  logic          EVENT_VALID;
  logic          EVENT_READY;
  logic          FLUSH;
  logic [$clog2(DEPTH):0] FIFO_COUNT;
  logic [CB-1:0] EVENT_CNT;

  aer_event_receiver #(
    .AER_ADDR_BITS(AB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_BITS(CB)
  ) dut (
    .CLK(CLK), .RST(RST), .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ),
    .AERIN_ACK(AERIN_ACK), .EVENT_ADDR(EVENT_ADDR), .EVENT_VALID(EVENT_VALID),
    .EVENT_READY(EVENT_READY), .FLUSH(FLUSH), .FIFO_COUNT(FIFO_COUNT),
    .EVENT_CNT(EVENT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a request is noticed SYNC edges after it is sampled,
  // the buffer is a plain queue, and every accepted pop is logged.
  logic [AB-1:0] m_q[$];
  logic [AB-1:0] popped_log[$];
  logic          req_hist[$];
  logic          m_ack;
  int            m_cnt;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q.delete();
      req_hist.delete();
      for (int i = 0; i < SYNC; i++) req_hist.push_back(1'b0);
      m_ack = 1'b0;
      m_cnt = 0;
    end else begin
      logic seen, accept, take;
      seen = req_hist.pop_front();
      req_hist.push_back(AERIN_REQ);
      accept = !m_ack && seen && (m_q.size() < DEPTH);
      take = (m_q.size() > 0) && EVENT_READY;
      if (accept) m_ack = 1'b1;
      else if (m_ack && !seen) m_ack = 1'b0;
      if (FLUSH) begin
        m_q.delete();
        m_cnt = 0;
      end else begin
        if (take) popped_log.push_back(m_q.pop_front());
        if (accept) begin
          m_q.push_back(AERIN_ADDR);
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (!RST) begin
      check("model_ack", 32'(AERIN_ACK), 32'(m_ack));
      check("model_valid", 32'(EVENT_VALID), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("model_addr", 32'(EVENT_ADDR), 32'(m_q[0]));
      check("model_count", 32'(FIFO_COUNT), 32'(m_q.size()));
      check("model_evcnt", 32'(EVENT_CNT), 32'(m_cnt));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    compare_model();
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int n = 0;
    while (AERIN_ACK !== v && n < 60) begin
      tick();
      n++;
    end
    check(nm, 32'(AERIN_ACK), 32'(v));
  endtask

  task automatic send(input logic [AB-1:0] a);
    AERIN_ADDR = a;
    AERIN_REQ = 1'b1;
    wait_ack(1'b1, "hs_ack_rise");
    tick();
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
    tick();
  endtask

  task automatic flush_pulse();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  initial begin
    int start, sent, sp, cd, ready_pct;
    RST = 1'b1;
    AERIN_ADDR = '0;
    AERIN_REQ = 1'b0;
    EVENT_READY = 1'b0;
    FLUSH = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_ack", 32'(AERIN_ACK), 0);
    check("rst_valid", 32'(EVENT_VALID), 0);
    check("rst_addr", 32'(EVENT_ADDR), 0);
    check("rst_count", 32'(FIFO_COUNT), 0);
    check("rst_evcnt", 32'(EVENT_CNT), 0);
    RST = 1'b0;
    tick();

    // single event: ACK three edges after REQ, data visible alongside it
    AERIN_ADDR = 10'd57;
    AERIN_REQ = 1'b1;
    tick();
    tick();
    check("single_ack_edge2", 32'(AERIN_ACK), 0);
    tick();
    check("single_ack_edge3", 32'(AERIN_ACK), 1);
    check("single_valid", 32'(EVENT_VALID), 1);
    check("single_addr", 32'(EVENT_ADDR), 57);
    check("single_evcnt", 32'(EVENT_CNT), 1);
    AERIN_REQ = 1'b0;
    tick();
    tick();
    check("single_ack_hold", 32'(AERIN_ACK), 1);
    tick();
    check("single_ack_fall", 32'(AERIN_ACK), 0);
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
    check("single_popped", 32'(EVENT_VALID), 0);

    // back-pressure
    flush_pulse();
    for (int i = 0; i < DEPTH; i++) send(AB'(i));
    check("bp_count_full", 32'(FIFO_COUNT), DEPTH);
    AERIN_ADDR = 10'd8;
    AERIN_REQ = 1'b1;
    repeat (10) tick();
    check("bp_no_ack", 32'(AERIN_ACK), 0);
    check("bp_count_held", 32'(FIFO_COUNT), DEPTH);
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
    check("bp_after_pop", 32'(FIFO_COUNT), DEPTH - 1);
    wait_ack(1'b1, "bp_ack_late");
    check("bp_count_refill", 32'(FIFO_COUNT), DEPTH);
    check("bp_head", 32'(EVENT_ADDR), 1);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    tick();

    // simultaneous push and pop
    flush_pulse();
    for (int i = 0; i < 4; i++) send(AB'(40 + i));
    AERIN_ADDR = 10'd44;
    AERIN_REQ = 1'b1;
    tick();
    tick();
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
    check("pp_ack", 32'(AERIN_ACK), 1);
    check("pp_count", 32'(FIFO_COUNT), 4);
    check("pp_head", 32'(EVENT_ADDR), 41);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "pp_ack_fall");
    tick();

    // ordering across pointer wrap
    flush_pulse();
    start = popped_log.size();
    EVENT_READY = 1'b1;
    for (int i = 0; i < 20; i++) send(AB'(255 - i));
    repeat (4) tick();
    EVENT_READY = 1'b0;
    check("wrap_npop", 32'(popped_log.size() - start), 20);
    for (int i = 0; i < 20 && start + i < popped_log.size(); i++)
      check("wrap_order", 32'(popped_log[start + i]), 32'(255 - i));
    check("wrap_evcnt", 32'(EVENT_CNT), 20);
    check("wrap_count", 32'(FIFO_COUNT), 0);

    // flush during a live handshake
    flush_pulse();
    for (int i = 0; i < 5; i++) send(AB'(100 + i));
    AERIN_ADDR = 10'd200;
    AERIN_REQ = 1'b1;
    wait_ack(1'b1, "fl_ack_rise");
    check("fl_count6", 32'(FIFO_COUNT), 6);
    flush_pulse();
    check("fl_count", 32'(FIFO_COUNT), 0);
    check("fl_evcnt", 32'(EVENT_CNT), 0);
    check("fl_valid", 32'(EVENT_VALID), 0);
    check("fl_ack_kept", 32'(AERIN_ACK), 1);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "fl_ack_fall");
    tick();
    send(10'd300);
    check("fl_next_evcnt", 32'(EVENT_CNT), 1);

    // asynchronous reset mid-handshake, REQ held through release
    AERIN_ADDR = 10'd77;
    AERIN_REQ = 1'b1;
    wait_ack(1'b1, "ar_ack_rise");
    #2 RST = 1'b1;
    #1;
    check("ar_ack_now", 32'(AERIN_ACK), 0);
    check("ar_count_now", 32'(FIFO_COUNT), 0);
    @(negedge CLK);
    RST = 1'b0;
    wait_ack(1'b1, "ar_new_event");
    check("ar_evcnt", 32'(EVENT_CNT), 1);
    check("ar_count", 32'(FIFO_COUNT), 1);
    check("ar_addr", 32'(EVENT_ADDR), 77);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "ar_ack_fall");
    tick();

    // randomized traffic with a behavioural sender
    sent = 0;
    sp = 0;
    cd = 0;
    for (int cyc = 0; cyc < 8000 && sent < 200; cyc++) begin
      ready_pct = ((cyc / 250) % 2 == 1) ? 85 : 15;
      EVENT_READY = ($urandom_range(0, 99) < ready_pct);
      FLUSH = ($urandom_range(0, 149) == 0);
      case (sp)
        0: if (cd == 0) begin
             AERIN_ADDR = AB'($urandom_range(0, 1023));
             AERIN_REQ = 1'b1;
             sp = 1;
           end else cd--;
        1: if (AERIN_ACK) begin cd = $urandom_range(0, 3); sp = 2; end
        2: if (cd == 0) begin AERIN_REQ = 1'b0; sp = 3; end else cd--;
        default: if (!AERIN_ACK) begin sent++; cd = $urandom_range(0, 4); sp = 0; end
      endcase
      tick();
    end
    FLUSH = 1'b0;
    EVENT_READY = 1'b0;
    AERIN_REQ = 1'b0;
    check("rand_done", 32'(sent >= 200), 1);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
